alu_cmd_scheduler: RTL and testbench

Command front-end for the 32-bit ALU. It queues operation requests (a, b, sel, c_in) in a small FIFO and issues them one at a time to the ALU. Single-cycle ops are sampled after one issue cycle. The multi-cycle MOD op (sel=111) is sequenced through the ALU start/done handshake, with a timeout. Each result is returned on a valid/ready response channel, in issue order.

---
 rtl/alu_sched_pkg.sv | 21 ++
 rtl/alu_cmd_fifo.sv | 70 +++++++
 rtl/alu_cmd_scheduler.sv | 159 +++++++++++++++
 tb/tb_alu_cmd_scheduler.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU command scheduler.
package alu_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StModArm,
    StModWait,
    StResp
  } state_e;

  localparam logic [2:0] SEL_MOD = 3'b111;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;
    logic        cin;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty flags; DEPTH must be a power of 2.
module alu_cmd_fifo
  import alu_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  cmd_t wdata_i,
  input  logic pop_i,
  output cmd_t rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push_i && !full_q;
    do_pop   = pop_i && !empty_q;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset; the flags gate every read.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/alu_cmd_scheduler.sv
// Queues ALU requests and issues them one at a time; MOD is sequenced through
// the ALU start/done handshake with a timeout. Responses return in issue order.
module alu_cmd_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned MOD_TIMEOUT = 1024,
  parameter int unsigned TW          = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [2:0]  cmd_sel,
  input  logic        cmd_cin,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_sel,
  output logic        alu_cin,
  output logic        alu_start,
  input  logic [31:0] alu_result,
  input  logic        alu_cout,
  input  logic        alu_done,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_cout,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam logic [TW-1:0] TmoLast = TW'(MOD_TIMEOUT - 1);

  cmd_t          push_cmd, head_cmd;
  logic          fifo_full, fifo_empty, fifo_pop;
  state_e        state_q, state_d;
  cmd_t          alu_q, alu_d;
  logic [31:0]   rsp_result_q, rsp_result_d;
  logic          rsp_cout_q, rsp_cout_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_expired;

  assign push_cmd = '{a: cmd_a, b: cmd_b, sel: cmd_sel, cin: cmd_cin};

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (cmd_valid && cmd_ready),
    .wdata_i (push_cmd),
    .pop_i   (fifo_pop),
    .rdata_o (head_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Counter holds the number of MOD cycles already spent; this is the last allowed one.
  assign tmo_expired = (tmo_cnt_q == TmoLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (!fifo_empty) state_d = StIssue;
      StIssue:   state_d = (alu_q.sel == SEL_MOD) ? StModArm : StResp;
      StModArm: begin
        if (tmo_expired) begin
          state_d = StResp;
        end else if (!alu_done) begin
          state_d = StModWait;
        end
      end
      StModWait: if (alu_done || tmo_expired) state_d = StResp;
      StResp:    if (rsp_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    fifo_pop      = 1'b0;
    alu_d         = alu_q;
    tmo_cnt_d     = tmo_cnt_q;
    rsp_result_d  = rsp_result_q;
    rsp_cout_d    = rsp_cout_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          alu_d    = head_cmd;
        end
      end
      StIssue: begin
        tmo_cnt_d = '0;
        if (alu_q.sel != SEL_MOD) begin
          rsp_result_d  = alu_result;
          rsp_cout_d    = alu_cout;
          rsp_timeout_d = 1'b0;
        end
      end
      StModArm, StModWait: begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
        // A done seen in ARM belongs to the previous MOD; only WAIT may accept it.
        if (state_q == StModWait && alu_done) begin
          rsp_result_d  = alu_result;
          rsp_cout_d    = alu_cout;
          rsp_timeout_d = 1'b0;
        end else if (tmo_expired) begin
          rsp_result_d  = '0;
          rsp_cout_d    = 1'b0;
          rsp_timeout_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_q         <= '0;
      tmo_cnt_q     <= '0;
      rsp_result_q  <= '0;
      rsp_cout_q    <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      alu_q         <= alu_d;
      tmo_cnt_q     <= tmo_cnt_d;
      rsp_result_q  <= rsp_result_d;
      rsp_cout_q    <= rsp_cout_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    cmd_ready   = !fifo_full;
    alu_a       = alu_q.a;
    alu_b       = alu_q.b;
    alu_sel     = alu_q.sel;
    alu_cin     = alu_q.cin;
    alu_start   = (state_q == StModWait);
    rsp_valid   = (state_q == StResp);
    rsp_result  = rsp_result_q;
    rsp_cout    = rsp_cout_q;
    rsp_timeout = rsp_timeout_q;
    busy        = !fifo_empty || (state_q != StIdle);
  end

endmodule

// File: tb/tb_alu_cmd_scheduler.sv
// Directed bench for alu_cmd_scheduler with a behavioural ADD/MOD ALU model.
module tb_alu_cmd_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic [2:0]  cmd_sel = '0;
  logic        cmd_cin = 1'b0;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_sel;
  logic        alu_cin, alu_start;
  logic [31:0] alu_result;
  logic        alu_cout;
  logic        alu_done;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_cout, rsp_timeout, busy;

  int vectors = 0;
  int miscompares = 0;
  bit no_done = 1'b0;
  int stale_len = 0;
  int mcnt, hold;

  always #5 clk = ~clk;

  alu_cmd_scheduler #(
    .DEPTH       (4),
    .MOD_TIMEOUT (16),
    .TW          (11)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_sel     (cmd_sel),
    .cmd_cin     (cmd_cin),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_cin     (alu_cin),
    .alu_start   (alu_start),
    .alu_result  (alu_result),
    .alu_cout    (alu_cout),
    .alu_done    (alu_done),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_cout    (rsp_cout),
    .rsp_timeout (rsp_timeout),
    .busy        (busy)
  );

  always_comb begin
    alu_result = '0;
    alu_cout   = 1'b0;
    case (alu_sel)
      3'b000:  {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
      3'b111:  alu_result = (alu_b == 32'd0) ? 32'd0 : alu_a % alu_b;
      default: ;
    endcase
  end

  // done rises after start has been seen for 9 edges (start held 10 cycles in total);
  // it may then stay high for stale_len extra cycles once start drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_done <= 1'b0;
      mcnt     <= 0;
      hold     <= 0;
    end else if (alu_start) begin
      hold <= 0;
      if (!no_done && mcnt == 8) alu_done <= 1'b1;
      mcnt <= mcnt + 1;
    end else begin
      mcnt <= 0;
      if (alu_done && hold < stale_len) begin
        hold <= hold + 1;
      end else begin
        alu_done <= 1'b0;
        hold     <= 0;
      end
    end
  end

  task automatic drive_cmd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel,
                           input logic cin);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_sel   = sel;
    cmd_cin   = cin;
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
    end
    vectors++;
    if ({rsp_valid, alu_start, busy, rsp_timeout} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got rsp_valid/start/busy/tmo=%b want 0000",
               {rsp_valid, alu_start, busy, rsp_timeout});
    end
    vectors++;
    if ({alu_a, rsp_result} !== 64'd0) begin
      miscompares++; $display("FAIL reset_data: got alu_a=%0h rsp=%0h want 0", alu_a, rsp_result);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({cmd_ready, busy} !== 2'b10) begin
      miscompares++; $display("FAIL post_reset: got ready/busy=%b want 10", {cmd_ready, busy});
    end
  endtask

  task automatic test_add;
    rsp_ready = 1'b1;
    drive_cmd(32'd100, 32'd60, 3'b000, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    vectors++;
    if ({alu_a, busy, rsp_valid} !== {32'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL add_cycle1: got alu_a=%0d busy=%b valid=%b want 0 1 0", alu_a, busy, rsp_valid);
    end
    @(negedge clk);
    vectors++;
    if ({alu_a, alu_b, rsp_valid} !== {32'd100, 32'd60, 1'b0}) begin
      miscompares++;
      $display("FAIL add_pop: got a=%0d b=%0d valid=%b want 100 60 0", alu_a, alu_b, rsp_valid);
    end
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_result, rsp_cout, rsp_timeout} !== {1'b1, 32'd160, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL add_rsp: got valid=%b res=%0d cout=%b tmo=%b want 1 160 0 0",
               rsp_valid, rsp_result, rsp_cout, rsp_timeout);
    end
    @(negedge clk);
    vectors++;
    if ({rsp_valid, busy} !== 2'b00) begin
      miscompares++; $display("FAIL add_idle: got valid/busy=%b want 00", {rsp_valid, busy});
    end
  endtask

  task automatic test_mod;
    int start_cnt = 0;
    rsp_ready = 1'b1;
    drive_cmd(32'd100, 32'd6, 3'b111, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) break;
      if (alu_start) start_cnt++;
      @(negedge clk);
    end
    vectors++;
    if (rsp_valid !== 1'b1) begin
      miscompares++; $display("FAIL mod_rsp_timeout_bound: got valid=%b want 1", rsp_valid);
    end
    vectors++;
    if ({rsp_result, rsp_timeout, alu_start} !== {32'd4, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL mod_rsp: got res=%0d tmo=%b start=%b want 4 0 0",
               rsp_result, rsp_timeout, alu_start);
    end
    vectors++;
    if (start_cnt !== 10) begin
      miscompares++; $display("FAIL mod_start_len: got %0d cycles want 10", start_cnt);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout;
    int cyc = 2;
    rsp_ready = 1'b1;
    no_done   = 1'b1;
    drive_cmd(32'd7, 32'd3, 3'b111, 1'b0);
    @(negedge clk);
    drive_cmd(32'd5, 32'd9, 3'b000, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    while (cyc < 60 && !rsp_valid) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc !== 19) begin
      miscompares++; $display("FAIL tmo_latency: got rsp at cycle %0d want 19", cyc);
    end
    vectors++;
    if ({rsp_valid, rsp_timeout, rsp_result, rsp_cout} !== {1'b1, 1'b1, 32'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL tmo_rsp: got valid=%b tmo=%b res=%0d cout=%b want 1 1 0 0",
               rsp_valid, rsp_timeout, rsp_result, rsp_cout);
    end
    no_done = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_result, rsp_timeout} !== {1'b1, 32'd15, 1'b0}) begin
      miscompares++;
      $display("FAIL tmo_next_add: got valid=%b res=%0d tmo=%b want 1 15 0",
               rsp_valid, rsp_result, rsp_timeout);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [31:0] ta [6];
    logic [31:0] tb [6];
    logic        tc [6];
    logic [31:0] er [6];
    logic        eco [6];
    int          accepted = 0;
    int          got = 0;
    bit          acc_now;
    ta  = '{32'd10, 32'd2000, 32'hFFFF_FFF0, 32'd12345, 32'd7, 32'h8000_0000};
    tb  = '{32'd20, 32'd3000, 32'h0000_0020, 32'd1, 32'd0, 32'h8000_0000};
    tc  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    er  = '{32'd30, 32'd5001, 32'h0000_0010, 32'd12347, 32'd8, 32'd0};
    eco = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    rsp_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (accepted == 6) break;
      drive_cmd(ta[accepted], tb[accepted], 3'b000, tc[accepted]);
      if (!cmd_ready) break;
      @(negedge clk);
      accepted++;
    end
    vectors++;
    if (accepted !== 5) begin
      miscompares++; $display("FAIL bp_accepted: got %0d before ready low want 5", accepted);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({rsp_valid, rsp_result, cmd_ready} !== {1'b1, er[0], 1'b0}) begin
        miscompares++;
        $display("FAIL bp_hold: got valid=%b res=%0d ready=%b want 1 %0d 0",
                 rsp_valid, rsp_result, cmd_ready, er[0]);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 100 && got < 6; i++) begin
      acc_now = cmd_valid && cmd_ready;
      if (rsp_valid) begin
        vectors++;
        if ({rsp_result, rsp_cout, rsp_timeout} !== {er[got], eco[got], 1'b0}) begin
          miscompares++;
          $display("FAIL bp_order[%0d]: got res=%0h cout=%b tmo=%b want %0h %b 0",
                   got, rsp_result, rsp_cout, rsp_timeout, er[got], eco[got]);
        end
        got++;
      end
      @(negedge clk);
      if (acc_now) begin
        cmd_valid = 1'b0;
        accepted++;
      end
    end
    vectors++;
    if ({got, accepted} !== {32'd6, 32'd6}) begin
      miscompares++; $display("FAIL bp_count: got rsp=%0d acc=%0d want 6 6", got, accepted);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stale_done;
    int nrsp = 0;
    int start2 = 0;
    int bad = 0;
    bit saw_stale = 1'b0;
    bit prev_start = 1'b0;
    rsp_ready = 1'b1;
    stale_len = 5;
    drive_cmd(32'd1000, 32'd7, 3'b111, 1'b0);
    @(negedge clk);
    drive_cmd(32'd77, 32'd10, 3'b111, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 80 && nrsp < 2; i++) begin
      if (alu_start && !prev_start && alu_done) bad++;
      if (nrsp == 1) begin
        if (alu_start) start2++;
        if (!alu_start && alu_done && !rsp_valid) saw_stale = 1'b1;
      end
      if (rsp_valid) begin
        vectors++;
        if ({rsp_result, rsp_timeout} !== {(nrsp == 0) ? 32'd6 : 32'd7, 1'b0}) begin
          miscompares++;
          $display("FAIL stale_rsp[%0d]: got res=%0d tmo=%b want %0d 0",
                   nrsp, rsp_result, rsp_timeout, (nrsp == 0) ? 6 : 7);
        end
        nrsp++;
      end
      prev_start = alu_start;
      @(negedge clk);
    end
    vectors++;
    if ({nrsp, start2} !== {32'd2, 32'd10}) begin
      miscompares++; $display("FAIL stale_seq: got rsp=%0d start2=%0d want 2 10", nrsp, start2);
    end
    vectors++;
    if ({bad, saw_stale} !== {32'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL stale_start: got early_starts=%0d stale_seen=%b want 0 1", bad, saw_stale);
    end
    stale_len = 0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    bit seen_start = 1'b0;
    bit seen_rsp = 1'b0;
    bit seen_busy = 1'b0;
    rsp_ready = 1'b1;
    drive_cmd(32'd50, 32'd7, 3'b111, 1'b0);
    @(negedge clk);
    drive_cmd(32'd1, 32'd2, 3'b000, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (alu_start) begin
        seen_start = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vectors++;
    if (seen_start !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_wait: got start=%b want 1", seen_start);
    end
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({alu_start, rsp_valid, busy, cmd_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL rstmid_async: got start/valid/busy/ready=%b want 0001",
               {alu_start, rsp_valid, busy, cmd_ready});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp = 1'b1;
      if (busy) seen_busy = 1'b1;
    end
    vectors++;
    if ({seen_rsp, seen_busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL rstmid_after: got rsp_seen=%b busy_seen=%b want 0 0", seen_rsp, seen_busy);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mod();
    test_timeout();
    test_back_to_back();
    test_stale_done();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
